// File: rtl/esn_readout.sv
// Readout y = sum Wout[i]*x[i] (Q3.12), two multipliers over 4 beats; ESN_READOUT_SAT_EN saturates, else wraps.
// Latency 5 cycles from ADDR_OUT change; no backpressure: samples arriving mid-MAC are dropped and raise OVERRUN.
module esn_readout #(
   parameter int FRAC_BITS = 12,
   parameter int AW        = 6
) (
   input  logic           clk,
   input  logic           rst_N,
   input  logic [127:0]   XSTATE,
   input  logic [AW-1:0]  ADDR_OUT,
   input  logic           wout_we,
   input  logic [2:0]     wout_addr,
   input  logic [15:0]    wout_data,
   output logic [15:0]    Y,
   output logic           Y_VALID,
   output logic [AW-1:0]  Y_ADDR,
   output logic           OVERRUN
);
   typedef enum logic {S_IDLE, S_MAC} state_t;

   state_t              state_q, state_d;
   logic [AW-1:0]       last_addr_q, last_addr_d;
   logic [AW-1:0]       tag_addr_q, tag_addr_d;
   logic [AW-1:0]       y_addr_q, y_addr_d;
   logic [7:0][15:0]    wshadow_q, wshadow_d;
   logic [7:0][15:0]    wact_q, wact_d;
   logic [7:0][15:0]    snap_q, snap_d;
   logic signed [34:0]  acc_q, acc_d;
   logic [1:0]          beat_q, beat_d;
   logic [15:0]         y_q, y_d;
   logic                y_vld_q, y_vld_d;
   logic                overrun_q, overrun_d;

   logic                new_sample, capture, mac_en, done, drop;
   logic [2:0]          idx_hi, idx_lo;
   logic signed [31:0]  prod_hi, prod_lo;
   logic signed [34:0]  acc_sum, shifted;
   logic [15:0]         y_res;

   always_ff @(posedge clk) begin
      if (!rst_N) begin
         state_q     <= S_IDLE;
         last_addr_q <= '0;
         tag_addr_q  <= '0;
         y_addr_q    <= '0;
         wshadow_q   <= '0;
         wact_q      <= '0;
         snap_q      <= '0;
         acc_q       <= '0;
         beat_q      <= '0;
         y_q         <= '0;
         y_vld_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_addr_q <= last_addr_d;
         tag_addr_q  <= tag_addr_d;
         y_addr_q    <= y_addr_d;
         wshadow_q   <= wshadow_d;
         wact_q      <= wact_d;
         snap_q      <= snap_d;
         acc_q       <= acc_d;
         beat_q      <= beat_d;
         y_q         <= y_d;
         y_vld_q     <= y_vld_d;
         overrun_q   <= overrun_d;
      end
   end

   assign new_sample = (ADDR_OUT != last_addr_q);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (new_sample) state_d = S_MAC;
         S_MAC:   if (beat_q == 2'd3 && !new_sample) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // A sample landing on beat 3 is captured in the same cycle (back-to-back).
   always_comb begin
      capture = 1'b0;
      mac_en  = 1'b0;
      done    = 1'b0;
      drop    = 1'b0;
      case (state_q)
         S_IDLE: capture = new_sample;
         S_MAC: begin
            mac_en  = 1'b1;
            done    = (beat_q == 2'd3);
            capture = done && new_sample;
            drop    = !done && new_sample;
         end
         default: ;
      endcase
   end

   // Beat b consumes words 7-2b and 6-2b.
   assign idx_hi  = {~beat_q, 1'b1};
   assign idx_lo  = {~beat_q, 1'b0};
   assign prod_hi = $signed(snap_q[idx_hi]) * $signed(wact_q[idx_hi]);
   assign prod_lo = $signed(snap_q[idx_lo]) * $signed(wact_q[idx_lo]);
   assign acc_sum = acc_q + 35'(prod_hi) + 35'(prod_lo);
   assign shifted = acc_sum >>> FRAC_BITS;

   always_comb begin
      y_res = shifted[15:0];
`ifdef ESN_READOUT_SAT_EN
      if (shifted > 35'sd32767)
         y_res = 16'h7FFF;
      else if (shifted < -35'sd32768)
         y_res = 16'h8000;
`endif
   end

   always_comb begin
      last_addr_d = ADDR_OUT;
      tag_addr_d  = tag_addr_q;
      y_addr_d    = y_addr_q;
      wshadow_d   = wshadow_q;
      wact_d      = wact_q;
      snap_d      = snap_q;
      acc_d       = acc_q;
      beat_d      = beat_q;
      y_d         = y_q;
      y_vld_d     = 1'b0;
      overrun_d   = overrun_q | drop;
      if (wout_we)
         wshadow_d[wout_addr] = wout_data;
      if (mac_en) begin
         acc_d  = acc_sum;
         beat_d = beat_q + 2'd1;
      end
      if (done) begin
         y_d      = y_res;
         y_addr_d = tag_addr_q;
         y_vld_d  = 1'b1;
      end
      if (capture) begin
         snap_d     = XSTATE;
         tag_addr_d = ADDR_OUT;
         wact_d     = wshadow_q;
         acc_d      = '0;
         beat_d     = '0;
      end
   end

   assign Y       = y_q;
   assign Y_VALID = y_vld_q;
   assign Y_ADDR  = y_addr_q;
   assign OVERRUN = overrun_q;
endmodule
